// File: rtl/pipeline_ctrl.sv
// Hazard/stall/flush sequencer for the 5-stage IF/ID/EX/MEM/WB pipeline.
// Control outputs are combinational from state and inputs; counters are registered.
module pipeline_ctrl #(
    parameter int unsigned WB_BYPASS   = 1,
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic        clk_in,
    input  logic        n_rst_in,
    input  logic [31:0] IFID_ir_in,
    input  logic [4:0]  IDEX_rd_in,
    input  logic        IDEX_ctrl_reg_write_in,
    input  logic [4:0]  EXMEM_rd_in,
    input  logic        EXMEM_ctrl_reg_write_in,
    input  logic [4:0]  MEMWB_rd_in,
    input  logic        MEMWB_ctrl_reg_write_in,
    input  logic        EXMEM_ctrl_branch_in,
    input  logic        EXMEM_alu_do_branch_in,
    input  logic        mem_req_in,
    input  logic        mem_ready_in,
    output logic        pc_write_en_out,
    output logic        pc_sel_branch_out,
    output logic        ifid_write_en_out,
    output logic        ifid_flush_out,
    output logic        idex_write_en_out,
    output logic        idex_bubble_out,
    output logic        exmem_write_en_out,
    output logic        exmem_flush_out,
    output logic        memwb_write_en_out,
    output logic        mem_error_out,
    output logic [15:0] stall_count_out
);

    localparam logic [5:0] OP_R   = 6'h00;
    localparam logic [5:0] OP_J   = 6'h02;
    localparam logic [5:0] OP_JAL = 6'h03;
    localparam logic [5:0] OP_BEQ = 6'h04;
    localparam logic [5:0] OP_BNE = 6'h05;
    localparam logic [5:0] OP_BLT = 6'h06;
    localparam logic [5:0] OP_BLE = 6'h07;
    localparam logic [5:0] OP_LUI = 6'h0F;
    localparam logic [5:0] OP_SB  = 6'h28;
    localparam logic [5:0] OP_SH  = 6'h29;
    localparam logic [5:0] OP_SW  = 6'h2B;

    localparam logic [7:0] TIMEOUT  = MEM_TIMEOUT[7:0];
    localparam logic       CHECK_WB = (WB_BYPASS == 0);

    typedef enum logic [1:0] {INIT, RUN, MEM_WAIT} state_t;

    state_t      state;
    state_t      state_next;
    logic [7:0]  wait_cnt;
    logic [7:0]  wait_inc;
    logic        mem_error;
    logic [15:0] stall_count;

    logic [5:0] opcode;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       uses_rs;
    logic       uses_rt;
    logic       hazard_rs;
    logic       hazard_rt;
    logic       hazard;
    logic       taken;
    logic       mem_busy;
    logic       unused_ir;

    assign opcode    = IFID_ir_in[31:26];
    assign rs        = IFID_ir_in[25:21];
    assign rt        = IFID_ir_in[20:16];
    assign unused_ir = ^IFID_ir_in[15:0];

    assign uses_rs = !(opcode inside {OP_J, OP_JAL, OP_LUI});
    assign uses_rt = opcode inside {OP_R, OP_BEQ, OP_BNE, OP_BLT, OP_BLE, OP_SW, OP_SH, OP_SB};

    function automatic logic src_conflict(input logic [4:0] src);
        logic hit;
        hit = (IDEX_ctrl_reg_write_in && (IDEX_rd_in == src))
           || (EXMEM_ctrl_reg_write_in && (EXMEM_rd_in == src))
           || (CHECK_WB && MEMWB_ctrl_reg_write_in && (MEMWB_rd_in == src));
        return (src != 5'd0) && hit;
    endfunction

    assign hazard_rs = uses_rs && src_conflict(rs);
    assign hazard_rt = uses_rt && src_conflict(rt);
    assign hazard    = hazard_rs || hazard_rt;
    assign taken     = EXMEM_ctrl_branch_in && EXMEM_alu_do_branch_in;
    assign mem_busy  = mem_req_in && !mem_ready_in;
    assign wait_inc  = (wait_cnt == 8'hFF) ? 8'hFF : wait_cnt + 8'd1;

    // RUN and MEM_WAIT share one decision: a wait that ends (ready or request
    // withdrawn) is just a RUN cycle without mem_busy.
    always_comb begin
        pc_write_en_out    = 1'b0;
        pc_sel_branch_out  = 1'b0;
        ifid_write_en_out  = 1'b0;
        ifid_flush_out     = 1'b0;
        idex_write_en_out  = 1'b0;
        idex_bubble_out    = 1'b0;
        exmem_write_en_out = 1'b0;
        exmem_flush_out    = 1'b0;
        memwb_write_en_out = 1'b0;
        state_next         = state;
        unique case (state)
            RUN, MEM_WAIT: begin
                if (mem_busy) begin
                    state_next = MEM_WAIT;
                end else begin
                    state_next         = RUN;
                    idex_write_en_out  = 1'b1;
                    exmem_write_en_out = 1'b1;
                    memwb_write_en_out = 1'b1;
                    if (taken) begin
                        pc_write_en_out   = 1'b1;
                        pc_sel_branch_out = 1'b1;
                        ifid_write_en_out = 1'b1;
                        ifid_flush_out    = 1'b1;
                        idex_bubble_out   = 1'b1;
                        exmem_flush_out   = 1'b1;
                    end else if (hazard) begin
                        idex_bubble_out = 1'b1;
                    end else begin
                        pc_write_en_out   = 1'b1;
                        ifid_write_en_out = 1'b1;
                    end
                end
            end
            default: begin
                ifid_flush_out  = 1'b1;
                idex_bubble_out = 1'b1;
                exmem_flush_out = 1'b1;
                state_next      = RUN;
            end
        endcase
    end

    always_ff @(posedge clk_in or negedge n_rst_in) begin
        if (!n_rst_in) begin
            state       <= INIT;
            wait_cnt    <= '0;
            mem_error   <= 1'b0;
            stall_count <= '0;
        end else begin
            state <= state_next;
            if ((state == MEM_WAIT) && mem_busy) begin
                wait_cnt <= wait_inc;
                if (wait_inc >= TIMEOUT) begin
                    mem_error <= 1'b1;
                end
            end else begin
                wait_cnt <= '0;
            end
            if ((state != INIT) && !pc_write_en_out && (stall_count != 16'hFFFF)) begin
                stall_count <= stall_count + 16'd1;
            end
        end
    end

    assign mem_error_out   = mem_error;
    assign stall_count_out = stall_count;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: two instances (default params; WB checked with short timeout)
// checked every cycle against a behavioural model, plus directed literal expectations.
module tb_pipeline_ctrl;

    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_J    = 6'h02;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_BNE  = 6'h05;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_LUI  = 6'h0F;
    localparam logic [5:0] OP_SW   = 6'h2B;

    // control vector bit order: pc_we pc_sel ifid_we ifid_flush idex_we idex_bubble exmem_we exmem_flush memwb_we
    localparam logic [8:0] V_INIT   = 9'b000101010;
    localparam logic [8:0] V_FLOW   = 9'b101010101;
    localparam logic [8:0] V_HOLD   = 9'b000011101;
    localparam logic [8:0] V_BRANCH = 9'b111111111;
    localparam logic [8:0] V_FREEZE = 9'b000000000;

    logic        clk_in = 1'b0;
    logic        n_rst_in;
    logic [31:0] IFID_ir_in;
    logic [4:0]  IDEX_rd_in, EXMEM_rd_in, MEMWB_rd_in;
    logic        IDEX_ctrl_reg_write_in, EXMEM_ctrl_reg_write_in, MEMWB_ctrl_reg_write_in;
    logic        EXMEM_ctrl_branch_in, EXMEM_alu_do_branch_in;
    logic        mem_req_in, mem_ready_in;

    logic [8:0]  ctrl_a, ctrl_b;
    logic        err_a, err_b;
    logic [15:0] stall_a, stall_b;

    int tests = 0;
    int fails = 0;
    bit run_checks = 0;

    always #5 clk_in = ~clk_in;

    pipeline_ctrl u_a (
        .clk_in(clk_in), .n_rst_in(n_rst_in), .IFID_ir_in(IFID_ir_in),
        .IDEX_rd_in(IDEX_rd_in), .IDEX_ctrl_reg_write_in(IDEX_ctrl_reg_write_in),
        .EXMEM_rd_in(EXMEM_rd_in), .EXMEM_ctrl_reg_write_in(EXMEM_ctrl_reg_write_in),
        .MEMWB_rd_in(MEMWB_rd_in), .MEMWB_ctrl_reg_write_in(MEMWB_ctrl_reg_write_in),
        .EXMEM_ctrl_branch_in(EXMEM_ctrl_branch_in), .EXMEM_alu_do_branch_in(EXMEM_alu_do_branch_in),
        .mem_req_in(mem_req_in), .mem_ready_in(mem_ready_in),
        .pc_write_en_out(ctrl_a[8]), .pc_sel_branch_out(ctrl_a[7]),
        .ifid_write_en_out(ctrl_a[6]), .ifid_flush_out(ctrl_a[5]),
        .idex_write_en_out(ctrl_a[4]), .idex_bubble_out(ctrl_a[3]),
        .exmem_write_en_out(ctrl_a[2]), .exmem_flush_out(ctrl_a[1]),
        .memwb_write_en_out(ctrl_a[0]), .mem_error_out(err_a), .stall_count_out(stall_a)
    );

    pipeline_ctrl #(.WB_BYPASS(0), .MEM_TIMEOUT(4)) u_b (
        .clk_in(clk_in), .n_rst_in(n_rst_in), .IFID_ir_in(IFID_ir_in),
        .IDEX_rd_in(IDEX_rd_in), .IDEX_ctrl_reg_write_in(IDEX_ctrl_reg_write_in),
        .EXMEM_rd_in(EXMEM_rd_in), .EXMEM_ctrl_reg_write_in(EXMEM_ctrl_reg_write_in),
        .MEMWB_rd_in(MEMWB_rd_in), .MEMWB_ctrl_reg_write_in(MEMWB_ctrl_reg_write_in),
        .EXMEM_ctrl_branch_in(EXMEM_ctrl_branch_in), .EXMEM_alu_do_branch_in(EXMEM_alu_do_branch_in),
        .mem_req_in(mem_req_in), .mem_ready_in(mem_ready_in),
        .pc_write_en_out(ctrl_b[8]), .pc_sel_branch_out(ctrl_b[7]),
        .ifid_write_en_out(ctrl_b[6]), .ifid_flush_out(ctrl_b[5]),
        .idex_write_en_out(ctrl_b[4]), .idex_bubble_out(ctrl_b[3]),
        .exmem_write_en_out(ctrl_b[2]), .exmem_flush_out(ctrl_b[1]),
        .memwb_write_en_out(ctrl_b[0]), .mem_error_out(err_b), .stall_count_out(stall_b)
    );

    task automatic check(input string name, input longint got, input longint exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit  model_bypass [2] = '{1'b1, 1'b0};
    int  model_tmo    [2] = '{255, 4};
    bit  active       [2];
    int  busy_run     [2];
    bit  model_err    [2];
    int  model_stalls [2];
    string bit_name [0:8] = '{"memwb_we", "exmem_flush", "exmem_we", "idex_bubble", "idex_we",
                              "ifid_flush", "ifid_we", "pc_sel", "pc_we"};

    function automatic bit raw_hazard(input bit bypass);
        int srcs[$];
        int dsts[$];
        logic [5:0] op;
        op = IFID_ir_in[31:26];
        if (!(op inside {OP_J, 6'h03, OP_LUI})) srcs.push_back(int'(IFID_ir_in[25:21]));
        if (op inside {OP_R, OP_BEQ, OP_BNE, 6'h06, 6'h07, OP_SW, 6'h29, 6'h28})
            srcs.push_back(int'(IFID_ir_in[20:16]));
        if (IDEX_ctrl_reg_write_in) dsts.push_back(int'(IDEX_rd_in));
        if (EXMEM_ctrl_reg_write_in) dsts.push_back(int'(EXMEM_rd_in));
        if (!bypass && MEMWB_ctrl_reg_write_in) dsts.push_back(int'(MEMWB_rd_in));
        foreach (srcs[s])
            foreach (dsts[d])
                if (srcs[s] != 0 && srcs[s] == dsts[d]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [8:0] expect_ctrl(input bit act, input bit bypass);
        if (!act) return V_INIT;
        if (mem_req_in && !mem_ready_in) return V_FREEZE;
        if (EXMEM_ctrl_branch_in && EXMEM_alu_do_branch_in) return V_BRANCH;
        if (raw_hazard(bypass)) return V_HOLD;
        return V_FLOW;
    endfunction

    // error sets once a run of consecutive busy cycles exceeds timeout+1 (first one is the RUN cycle)
    always @(posedge clk_in or negedge n_rst_in) begin
        if (!n_rst_in) begin
            for (int i = 0; i < 2; i++) begin
                active[i]       <= 1'b0;
                busy_run[i]     <= 0;
                model_err[i]    <= 1'b0;
                model_stalls[i] <= 0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                logic [8:0] e;
                e = expect_ctrl(active[i], model_bypass[i]);
                if (active[i] && mem_req_in && !mem_ready_in) begin
                    busy_run[i] <= busy_run[i] + 1;
                    if (busy_run[i] >= model_tmo[i]) model_err[i] <= 1'b1;
                end else begin
                    busy_run[i] <= 0;
                end
                if (active[i] && !e[8])
                    model_stalls[i] <= (model_stalls[i] >= 65535) ? 65535 : model_stalls[i] + 1;
                active[i] <= 1'b1;
            end
        end
    end

    always @(negedge clk_in) begin
        if (run_checks) begin
            for (int i = 0; i < 2; i++) begin
                logic [8:0]  e;
                logic [8:0]  g;
                string inst;
                e    = expect_ctrl(active[i], model_bypass[i]);
                g    = (i == 0) ? ctrl_a : ctrl_b;
                inst = (i == 0) ? "u_a" : "u_b";
                for (int b = 0; b < 9; b++)
                    check($sformatf("%s.%s", inst, bit_name[b]), longint'(g[b]), longint'(e[b]));
                check($sformatf("%s.mem_error", inst), longint'((i == 0) ? err_a : err_b),
                      longint'(model_err[i]));
                check($sformatf("%s.stall_count", inst), longint'((i == 0) ? stall_a : stall_b),
                      longint'(model_stalls[i]));
            end
        end
    end

    // ---------------- directed stimulus ----------------
    function automatic logic [31:0] rtype(input int rs, input int rt, input int rd);
        return {OP_R, rs[4:0], rt[4:0], rd[4:0], 11'h000};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input int rs, input int rt);
        return {op, rs[4:0], rt[4:0], 16'h0001};
    endfunction

    task automatic clear_inputs();
        IFID_ir_in = '0;
        IDEX_rd_in = '0;  IDEX_ctrl_reg_write_in = 1'b0;
        EXMEM_rd_in = '0; EXMEM_ctrl_reg_write_in = 1'b0;
        MEMWB_rd_in = '0; MEMWB_ctrl_reg_write_in = 1'b0;
        EXMEM_ctrl_branch_in = 1'b0; EXMEM_alu_do_branch_in = 1'b0;
        mem_req_in = 1'b0; mem_ready_in = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk_in);
        #1;
    endtask

    task automatic settle();
        @(negedge clk_in);
    endtask

    initial begin
        clear_inputs();
        n_rst_in = 1'b1;
        #1 n_rst_in = 1'b0;
        run_checks = 1'b1;

        // T1 reset and INIT
        settle();
        check("reset ctrl", ctrl_a, V_INIT);
        check("reset stall_count", stall_a, 0);
        next_cycle();
        n_rst_in = 1'b1;
        settle();
        check("init ctrl", ctrl_a, V_INIT);
        next_cycle();
        settle();
        check("first run ctrl", ctrl_a, V_FLOW);

        // T2 load-use against EX, then MEM, then WB
        next_cycle();
        IDEX_rd_in = 5; IDEX_ctrl_reg_write_in = 1'b1; IFID_ir_in = rtype(5, 6, 7);
        settle();
        check("load-use EX a", ctrl_a, V_HOLD);
        check("load-use EX b", ctrl_b, V_HOLD);
        next_cycle();
        IDEX_rd_in = 0; IDEX_ctrl_reg_write_in = 1'b0; EXMEM_rd_in = 5; EXMEM_ctrl_reg_write_in = 1'b1;
        settle();
        check("load-use MEM a", ctrl_a, V_HOLD);
        next_cycle();
        EXMEM_rd_in = 0; EXMEM_ctrl_reg_write_in = 1'b0; MEMWB_rd_in = 5; MEMWB_ctrl_reg_write_in = 1'b1;
        settle();
        check("WB bypass a", ctrl_a, V_FLOW);
        check("WB checked b", ctrl_b, V_HOLD);
        next_cycle();
        clear_inputs();
        settle();
        check("T2 stall_count a", stall_a, 2);
        check("T2 stall_count b", stall_b, 3);

        // T3 r0 and source-use rules
        next_cycle();
        IDEX_rd_in = 0; IDEX_ctrl_reg_write_in = 1'b1; IFID_ir_in = rtype(0, 0, 9);
        settle();
        check("r0 no stall", ctrl_a, V_FLOW);
        next_cycle();
        IDEX_rd_in = 3; IFID_ir_in = itype(OP_J, 3, 3);
        settle();
        check("J ignores fields", ctrl_a, V_FLOW);
        next_cycle();
        IFID_ir_in = itype(OP_ADDI, 1, 3);
        settle();
        check("ADDI rt unused", ctrl_a, V_FLOW);
        next_cycle();
        IFID_ir_in = itype(OP_SW, 1, 3);
        settle();
        check("SW rt hazard", ctrl_a, V_HOLD);
        next_cycle();
        IFID_ir_in = itype(OP_LUI, 3, 1);
        settle();
        check("LUI rs unused", ctrl_a, V_FLOW);
        next_cycle();
        IFID_ir_in = itype(OP_BNE, 3, 0);
        settle();
        check("BNE rs hazard", ctrl_a, V_HOLD);

        // T4 taken branch overrides ID hazard
        next_cycle();
        clear_inputs();
        EXMEM_ctrl_branch_in = 1'b1; EXMEM_alu_do_branch_in = 1'b1;
        IDEX_rd_in = 4; IDEX_ctrl_reg_write_in = 1'b1; IFID_ir_in = itype(OP_BEQ, 4, 0);
        settle();
        check("taken branch a", ctrl_a, V_BRANCH);
        check("taken branch b", ctrl_b, V_BRANCH);
        next_cycle();
        EXMEM_alu_do_branch_in = 1'b0;
        settle();
        check("not taken hazard", ctrl_a, V_HOLD);
        next_cycle();
        clear_inputs();
        settle();
        check("T4 stall_count a", stall_a, 5);
        check("T4 stall_count b", stall_b, 6);

        // T5 memory wait of 3 cycles, early request drop, exit with taken branch
        for (int k = 0; k < 3; k++) begin
            next_cycle();
            mem_req_in = 1'b1; mem_ready_in = 1'b0;
            settle();
            check($sformatf("mem freeze %0d", k), ctrl_a, V_FREEZE);
        end
        next_cycle();
        mem_ready_in = 1'b1;
        settle();
        check("mem ready resume", ctrl_a, V_FLOW);
        next_cycle();
        clear_inputs();
        settle();
        check("T5 stall_count a", stall_a, 8);
        check("T5 stall_count b", stall_b, 9);
        for (int k = 0; k < 2; k++) begin
            next_cycle();
            mem_req_in = 1'b1;
        end
        next_cycle();
        mem_req_in = 1'b0;
        settle();
        check("req drop resume", ctrl_a, V_FLOW);
        for (int k = 0; k < 2; k++) begin
            next_cycle();
            mem_req_in = 1'b1;
        end
        next_cycle();
        mem_ready_in = 1'b1; EXMEM_ctrl_branch_in = 1'b1; EXMEM_alu_do_branch_in = 1'b1;
        settle();
        check("ready with taken", ctrl_a, V_BRANCH);
        next_cycle();
        clear_inputs();
        settle();
        check("T5b stall_count a", stall_a, 12);

        // T6 timeout: u_b has MEM_TIMEOUT=4
        next_cycle();
        mem_req_in = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            if (k > 1) next_cycle();
            settle();
            check($sformatf("timeout b cycle %0d", k), err_b, (k >= 6) ? 1 : 0);
        end
        check("no timeout a", err_a, 0);
        next_cycle();
        clear_inputs();
        repeat (3) next_cycle();
        settle();
        check("mem_error sticky b", err_b, 1);

        // u_a default timeout of 255 wait cycles
        next_cycle();
        mem_req_in = 1'b1;
        for (int k = 1; k <= 260; k++) begin
            if (k > 1) next_cycle();
            settle();
            if (k == 256) check("timeout a edge-1", err_a, 0);
            if (k == 257) check("timeout a edge", err_a, 1);
        end

        // reset in the middle of a wait clears everything
        next_cycle();
        n_rst_in = 1'b0;
        settle();
        check("mid-wait reset ctrl", ctrl_a, V_INIT);
        check("mid-wait reset err a", err_a, 0);
        check("mid-wait reset err b", err_b, 0);
        check("mid-wait reset stalls", stall_a, 0);
        next_cycle();
        n_rst_in = 1'b1;
        clear_inputs();
        next_cycle();
        settle();
        check("post reset run", ctrl_a, V_FLOW);
        repeat (2) next_cycle();
        settle();
        run_checks = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
